// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared types and constants for the E-stage HI/LO multiply-divide issuer.
package muldiv_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} md_state_e;

  localparam logic [2:0] MULDIV_SELECT_LO = 3'd0;
  localparam logic [2:0] MULDIV_SELECT_HI = 3'd1;
  localparam logic [2:0] MULDIV_DO_MUL    = 3'd2;
  localparam logic [2:0] MULDIV_DO_MULU   = 3'd3;
  localparam logic [2:0] MULDIV_DO_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DO_DIVU   = 3'd5;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  function automatic logic is_start_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// E-stage / multiply-divide unit signal bundle; slave is the issuer side.
interface muldiv_issue_ctrl_if;
  logic                           req;
  logic                           e_valid;
  muldiv_issue_ctrl_pkg::md_op_e  e_op;
  logic [31:0]                    e_rs;
  logic [31:0]                    e_rt;
  logic                           md_busy;
  logic [31:0]                    md_c;
  logic                           md_start;
  logic                           md_we;
  logic [2:0]                     md_sel;
  logic [31:0]                    md_a;
  logic [31:0]                    md_b;
  logic                           stall;
  logic [31:0]                    e_result;
  logic                           proto_err;
  logic [31:0]                    stall_cnt;

  modport master (
    output req, e_valid, e_op, e_rs, e_rt, md_busy, md_c,
    input  md_start, md_we, md_sel, md_a, md_b, stall, e_result, proto_err, stall_cnt
  );

  modport slave (
    input  req, e_valid, e_op, e_rs, e_rt, md_busy, md_c,
    output md_start, md_we, md_sel, md_a, md_b, stall, e_result, proto_err, stall_cnt
  );
endinterface

// File: rtl/muldiv_issue_ctrl_shadow_counter.sv
// Shadow latency counter: mirrors the unit's busy window and flags any disagreement.
module md_shadow_counter
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  input  logic busy_i,
  output logic run_o,
  output logic proto_err_o
);

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             perr_q, perr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      state_d = ST_RUN;
      cnt_d   = is_div_i ? DIV_LD : MUL_LD;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
    end
    // Unit must be busy exactly while we believe an op is in flight.
    perr_d = perr_q | ((state_q == ST_RUN) != busy_i);
  end

  always_comb begin
    run_o       = (state_q == ST_RUN);
    proto_err_o = perr_q;
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// E-stage issuer: decodes md ops, drives the HI/LO unit, stalls while it is busy.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4   // 2**CNT_W must exceed max(MUL_LAT, DIV_LAT)
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_issue_ctrl_if.slave bus
);

  logic        md_class, run, stall, go;
  logic        start, we;
  logic [2:0]  sel;
  logic [31:0] result;
  logic        perr;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    md_class = bus.e_valid && (bus.e_op != MD_NONE);
    // A flushed instruction never waits; everything else waits out the in-flight op.
    stall    = md_class && run && !bus.req;
    go       = md_class && !bus.req && !stall;
    start    = go && is_start_op(bus.e_op);
    we       = go && ((bus.e_op == MD_MTHI) || (bus.e_op == MD_MTLO));
    case (bus.e_op)
      MD_MULT:          sel = MULDIV_DO_MUL;
      MD_MULTU:         sel = MULDIV_DO_MULU;
      MD_DIV:           sel = MULDIV_DO_DIV;
      MD_DIVU:          sel = MULDIV_DO_DIVU;
      MD_MTHI, MD_MFHI: sel = MULDIV_SELECT_HI;
      default:          sel = MULDIV_SELECT_LO;
    endcase
    result = (go && ((bus.e_op == MD_MFHI) || (bus.e_op == MD_MFLO))) ? bus.md_c : '0;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  md_shadow_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .is_div_i    (is_div_op(bus.e_op)),
    .busy_i      (bus.md_busy),
    .run_o       (run),
    .proto_err_o (perr)
  );

  assign bus.md_start  = start;
  assign bus.md_we     = we;
  assign bus.md_sel    = sel;
  assign bus.md_a      = bus.e_rs;
  assign bus.md_b      = bus.e_rt;
  assign bus.stall     = stall;
  assign bus.e_result  = result;
  assign bus.proto_err = perr;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: behavioural HI/LO unit plus a cycle-level reference model.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk, rst_n;
  muldiv_issue_ctrl_if ifc();

  muldiv_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural multiply/divide unit ----------------
  int          u_left;
  logic [31:0] u_hi, u_lo;
  bit          busy_kill;

  function automatic logic [63:0] calc(logic [2:0] sel, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    case (sel)
      MULDIV_DO_MUL:  return 64'(sa * sb);
      MULDIV_DO_MULU: return ua * ub;
      MULDIV_DO_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_left <= 0; u_hi <= '0; u_lo <= '0;
    end else begin
      if (ifc.md_start) begin
        u_left <= (ifc.md_sel == MULDIV_DO_DIV || ifc.md_sel == MULDIV_DO_DIVU) ? DL : ML;
        {u_hi, u_lo} <= calc(ifc.md_sel, ifc.md_a, ifc.md_b);
      end else if (u_left > 0) u_left <= u_left - 1;
      if (ifc.md_we) begin
        if (ifc.md_sel == MULDIV_SELECT_HI) u_hi <= ifc.md_a;
        else                                u_lo <= ifc.md_a;
      end
    end
  end

  assign ifc.md_busy = (u_left > 0) && !busy_kill;
  assign ifc.md_c    = (ifc.md_sel == MULDIV_SELECT_HI) ? u_hi : u_lo;

  // ---------------- reference model ----------------
  int          m_rem;   // cycles the in-flight op still occupies the unit
  int unsigned m_scnt;
  bit          m_perr;

  function automatic bit x_class();
    return ifc.e_valid && ifc.e_op != MD_NONE;
  endfunction
  function automatic bit x_stall();
    return x_class() && m_rem > 0 && !ifc.req;
  endfunction
  function automatic bit x_go();
    return x_class() && !ifc.req && m_rem == 0;
  endfunction
  function automatic bit x_start();
    return x_go() && ifc.e_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction
  function automatic bit x_we();
    return x_go() && ifc.e_op inside {MD_MTHI, MD_MTLO};
  endfunction
  function automatic logic [31:0] x_res();
    if (x_go() && ifc.e_op == MD_MFHI) return u_hi;
    if (x_go() && ifc.e_op == MD_MFLO) return u_lo;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_scnt = 0; m_perr = 0;
  endtask

  task automatic drive(bit v, md_op_e op, logic [31:0] rs, logic [31:0] rt, bit rq);
    ifc.e_valid = v; ifc.e_op = op; ifc.e_rs = rs; ifc.e_rt = rt; ifc.req = rq;
  endtask

  // One clock: advance the model with the values seen just before the edge.
  task automatic tick();
    bit st, go, sta;
    int lat;
    st  = x_stall();
    go  = x_go();
    sta = x_start();
    lat = (ifc.e_op inside {MD_DIV, MD_DIVU}) ? DL : ML;
    if (ifc.md_busy !== (m_rem > 0)) m_perr = 1;
    @(posedge clk);
    if (st && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (go && sta) m_rem = lat;
    else if (m_rem > 0) m_rem--;
    #1;
  endtask

  function automatic bit dut_run();
    return dut.u_shadow.state_q == ST_RUN;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
    #2;
    checks++; if (ifc.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", ifc.stall); end
    checks++; if (ifc.md_start !== 1'b0 || ifc.md_we !== 1'b0) begin errors++; $display("FAIL reset_start_we: got %0b/%0b want 0/0", ifc.md_start, ifc.md_we); end
    checks++; if (ifc.md_sel !== MULDIV_SELECT_LO) begin errors++; $display("FAIL reset_sel: got %0d want 0", ifc.md_sel); end
    checks++; if (ifc.e_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", ifc.e_result); end
    checks++; if (ifc.proto_err !== 1'b0 || ifc.stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt: got %0b/%0d want 0/0", ifc.proto_err, ifc.stall_cnt); end
    checks++; if (dut.u_shadow.cnt_q !== 4'd0 || dut_run()) begin errors++; $display("FAIL reset_cnt: got %0d run=%0b want 0 idle", dut.u_shadow.cnt_q, dut_run()); end
  endtask

  task automatic test_mult();
    drive(1, MD_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    #2;
    checks++; if (ifc.md_start !== 1'b1 || ifc.md_sel !== MULDIV_DO_MUL) begin errors++; $display("FAIL mult_issue: got start=%0b sel=%0d want 1/%0d", ifc.md_start, ifc.md_sel, MULDIV_DO_MUL); end
    checks++; if (ifc.md_a !== 32'hFFFF_FFFD || ifc.md_b !== 32'd7) begin errors++; $display("FAIL mult_operands: got %h/%h want fffffffd/7", ifc.md_a, ifc.md_b); end
    tick();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
    for (int c = 1; c <= 7; c++) begin
      #2;
      checks++; if (dut_run() !== (c <= ML)) begin errors++; $display("FAIL mult_state_c%0d: got run=%0b want %0b", c, dut_run(), (c <= ML)); end
      tick();
    end
    checks++; if (ifc.proto_err !== 1'b0) begin errors++; $display("FAIL mult_proto: got %0b want 0", ifc.proto_err); end
    drive(1, MD_MFLO, 32'd0, 32'd0, 0);
    #2;
    checks++; if (ifc.e_result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", ifc.e_result); end
    tick();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
  endtask

  task automatic test_div_stall();
    int unsigned base;
    base = m_scnt;
    drive(1, MD_DIVU, 32'd17, 32'd4, 0);
    #2;
    checks++; if (ifc.md_start !== 1'b1 || ifc.md_sel !== MULDIV_DO_DIVU) begin errors++; $display("FAIL divu_issue: got start=%0b sel=%0d want 1/%0d", ifc.md_start, ifc.md_sel, MULDIV_DO_DIVU); end
    tick();
    drive(1, MD_MFLO, 32'd0, 32'd0, 0);
    for (int c = 1; c <= DL; c++) begin
      #2;
      checks++; if (ifc.stall !== 1'b1 || ifc.e_result !== 32'd0) begin errors++; $display("FAIL divu_stall_c%0d: got stall=%0b res=%h want 1/0", c, ifc.stall, ifc.e_result); end
      tick();
    end
    #2;
    checks++; if (ifc.stall !== 1'b0 || ifc.e_result !== 32'd4) begin errors++; $display("FAIL divu_mflo: got stall=%0b res=%h want 0/4", ifc.stall, ifc.e_result); end
    checks++; if (ifc.stall_cnt !== base + 32'd10) begin errors++; $display("FAIL divu_stall_cnt: got %0d want %0d", ifc.stall_cnt, base + 10); end
    tick();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
  endtask

  task automatic test_mthi();
    drive(1, MD_MTHI, 32'hDEAD_BEEF, 32'd0, 0);
    #2;
    checks++; if (ifc.md_we !== 1'b1 || ifc.md_sel !== MULDIV_SELECT_HI || ifc.md_start !== 1'b0) begin errors++; $display("FAIL mthi_issue: got we=%0b sel=%0d start=%0b want 1/1/0", ifc.md_we, ifc.md_sel, ifc.md_start); end
    tick();
    checks++; if (dut.u_shadow.cnt_q !== 4'd0 || dut_run()) begin errors++; $display("FAIL mthi_cnt: got %0d want 0", dut.u_shadow.cnt_q); end
    drive(1, MD_MFHI, 32'd0, 32'd0, 0);
    #2;
    checks++; if (ifc.stall !== 1'b0 || ifc.e_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mfhi_read: got stall=%0b res=%h want 0/deadbeef", ifc.stall, ifc.e_result); end
    tick();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
  endtask

  task automatic test_req();
    drive(1, MD_DIV, 32'd100, 32'd7, 1);
    #2;
    checks++; if (ifc.md_start !== 1'b0 || ifc.stall !== 1'b0) begin errors++; $display("FAIL req_div: got start=%0b stall=%0b want 0/0", ifc.md_start, ifc.stall); end
    tick();
    checks++; if (dut_run() || dut.u_shadow.cnt_q !== 4'd0) begin errors++; $display("FAIL req_div_idle: got run=%0b cnt=%0d want idle/0", dut_run(), dut.u_shadow.cnt_q); end
    drive(1, MD_MULT, 32'd5, 32'd6, 0);
    tick();
    drive(1, MD_MULT, 32'd1, 32'd1, 1);
    #2;
    checks++; if (ifc.stall !== 1'b0 || ifc.md_start !== 1'b0) begin errors++; $display("FAIL req_run: got stall=%0b start=%0b want 0/0", ifc.stall, ifc.md_start); end
    tick();
    checks++; if (dut.u_shadow.cnt_q !== 4'd4) begin errors++; $display("FAIL req_cnt: got %0d want 4", dut.u_shadow.cnt_q); end
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    drive(1, MD_MULT, 32'd2, 32'd3, 0);
    tick();
    drive(1, MD_MULT, 32'd4, 32'd5, 0);
    for (int c = 1; c <= ML; c++) begin
      #2;
      checks++; if (ifc.stall !== 1'b1 || ifc.md_start !== 1'b0) begin errors++; $display("FAIL b2b_stall_c%0d: got stall=%0b start=%0b want 1/0", c, ifc.stall, ifc.md_start); end
      tick();
    end
    #2;
    checks++; if (ifc.stall !== 1'b0 || ifc.md_start !== 1'b1) begin errors++; $display("FAIL b2b_issue: got stall=%0b start=%0b want 0/1", ifc.stall, ifc.md_start); end
    tick();
    checks++; if (dut.u_shadow.cnt_q !== 4'd5) begin errors++; $display("FAIL b2b_reload: got %0d want 5", dut.u_shadow.cnt_q); end
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
    repeat (5) tick();
    drive(1, MD_MFLO, 32'd0, 32'd0, 0);
    #2;
    checks++; if (ifc.e_result !== 32'd20) begin errors++; $display("FAIL b2b_lo: got %h want 14", ifc.e_result); end
    tick();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
  endtask

  task automatic test_proto();
    drive(1, MD_MULT, 32'd1, 32'd1, 0);
    tick();
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
    tick();
    tick();
    busy_kill = 1;
    #2;
    checks++; if (ifc.proto_err !== 1'b0) begin errors++; $display("FAIL proto_early: got %0b want 0", ifc.proto_err); end
    tick();
    busy_kill = 0;
    #2;
    checks++; if (ifc.proto_err !== 1'b1 || ifc.proto_err !== m_perr) begin errors++; $display("FAIL proto_flag: got %0b want 1", ifc.proto_err); end
    repeat (5) tick();
    checks++; if (ifc.proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %0b want 1", ifc.proto_err); end
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.proto_err !== 1'b0) begin errors++; $display("FAIL proto_reset: got %0b want 0", ifc.proto_err); end
    model_reset();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    drive(1, MD_DIV, 32'd50, 32'd3, 0);
    tick();
    drive(1, MD_MFLO, 32'd0, 32'd0, 0);
    repeat (4) tick();
    #2;
    checks++; if (dut.u_shadow.cnt_q !== 4'd6 || ifc.stall !== 1'b1) begin errors++; $display("FAIL arst_pre: got cnt=%0d stall=%0b want 6/1", dut.u_shadow.cnt_q, ifc.stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (dut.u_shadow.cnt_q !== 4'd0 || ifc.stall !== 1'b0) begin errors++; $display("FAIL arst_cnt: got cnt=%0d stall=%0b want 0/0", dut.u_shadow.cnt_q, ifc.stall); end
    checks++; if (ifc.stall_cnt !== 32'd0 || ifc.proto_err !== 1'b0) begin errors++; $display("FAIL arst_regs: got scnt=%0d perr=%0b want 0/0", ifc.stall_cnt, ifc.proto_err); end
    model_reset();
    #2 rst_n = 1'b1;
    drive(0, MD_NONE, 32'd0, 32'd0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), md_op_e'($urandom_range(0, 8)),
            $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom,
            ($urandom_range(0, 9) == 0));
      #2;
      checks++; if (ifc.stall !== x_stall() || ifc.md_start !== x_start() || ifc.md_we !== x_we()) begin errors++; $display("FAIL rnd_ctrl_%0d: got stall/start/we=%0b%0b%0b want %0b%0b%0b", i, ifc.stall, ifc.md_start, ifc.md_we, x_stall(), x_start(), x_we()); end
      checks++; if (ifc.e_result !== x_res()) begin errors++; $display("FAIL rnd_result_%0d: got %h want %h", i, ifc.e_result, x_res()); end
      tick();
    end
    checks++; if (ifc.stall_cnt !== m_scnt || ifc.proto_err !== m_perr) begin errors++; $display("FAIL rnd_totals: got scnt=%0d perr=%0b want %0d/%0b", ifc.stall_cnt, ifc.proto_err, m_scnt, m_perr); end
  endtask

  initial begin
    rst_n = 1'b0;
    busy_kill = 0;
    model_reset();
    test_reset();
    #5 rst_n = 1'b1;
    tick();
    test_mult();
    test_div_stall();
    test_mthi();
    test_req();
    test_back_to_back();
    test_proto();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- E-stage issuer for the HI/LO multiply-divide unit. It drives that unit's start/WE/sel/A/B and consumes its busy/C outputs.
- Decodes the E-stage md-class op. Issues starts and HI/LO writes, routes MFHI/MFLO data, and stalls the pipeline while an operation is in flight.
- Keeps a shadow latency counter and cross-checks it against the unit's busy, flagging protocol violations.

Parameters:
- MUL_LAT, 5, cycles the unit stays busy after a MULT/MULTU start.
- DIV_LAT, 10, cycles the unit stays busy after a DIV/DIVU start.
- CNT_W, 4, shadow counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  exception/interrupt flush of E-stage instruction this cycle
- e_valid  in  1  E-stage holds a valid instruction
- e_op  in  4  md op code (package enum: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO)
- e_rs  in  32  forwarded rs value
- e_rt  in  32  forwarded rt value
- md_busy  in  1  unit busy
- md_c  in  32  unit read data
- md_start  out  1  start pulse to unit
- md_we  out  1  HI/LO write to unit
- md_sel  out  3  unit select/op code
- md_a  out  32  operand A
- md_b  out  32  operand B
- stall  out  1  freeze F/D/E, bubble into M
- e_result  out  32  MFHI/MFLO data for E-stage result mux
- proto_err  out  1  sticky shadow/busy mismatch
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, proto_err=0, stall_cnt=0. All combinational outputs then evaluate to 0 / SEL_LO.
- States:
  - IDLE: cnt==0.
  - RUN: cnt>0; cnt decrements by 1 each cycle. RUN->IDLE on the edge where cnt goes 1->0.
- Definitions:
  - md_class = e_valid && e_op!=NONE.
  - go = md_class && !req && !stall.
- stall = md_class && (state==RUN) && !req. Every md op, including MTHI/MTLO/MFHI/MFLO, waits for the in-flight op. A flushed instruction never stalls.
- md_a=e_rs, md_b=e_rt always.
- md_sel:
  - MULT->DO_MUL, MULTU->DO_MULU, DIV->DO_DIV, DIVU->DO_DIVU.
  - MTHI/MFHI->SEL_HI; MTLO/MFLO->SEL_LO; otherwise SEL_LO.
- md_start = go && op∈{MULT,MULTU,DIV,DIVU}.
- md_we = go && op∈{MTHI,MTLO}.
- Outputs are combinational in the same cycle; the unit samples them on the next edge.
- On a md_start edge, cnt <= MUL_LAT (mul) or DIV_LAT (div) and state <= RUN.
- MTHI/MTLO never load cnt.
- e_result = md_c when go && op∈{MFHI,MFLO}, else 0.
- Check: from the edge after reset, each cycle compare (state==RUN) with md_busy. On mismatch, proto_err <= 1 and stays 1 until reset. Normal protocol gives busy high for exactly LAT cycles, starting the cycle after start.
- stall_cnt increments each cycle stall=1 and saturates at 32'hFFFFFFFF.
- req mid-operation: an in-flight op is not cancelled; cnt keeps counting. req only suppresses the current start/we and stall.
- Back-to-back: a second MULT in the cycle after start sees RUN and stalls LAT cycles. It issues in the first IDLE cycle, and cnt reloads on that edge.
- Async reset mid-RUN: cnt and state clear immediately. The unit is reset in the same event, so no mismatch is flagged.

Decomposition:
- Shared package/const header:
  - md op enum (4-bit).
  - MULDIV_SELECT_LO=0, SELECT_HI=1, DO_MUL=2, DO_MULU=3, DO_DIV=4, DO_DIVU=5.
  - MUL_LAT/DIV_LAT defaults.
- One natural sub-module: md_shadow_counter (load/decrement/busy compare, proto_err). Decode and muxing stay in the top.

Test Plan:
- MULT rs=-3, rt=7 at cycle 0 -> md_start=1, md_sel=DO_MUL at cycle 0; state RUN cycles 1–5, IDLE at 6; proto_err stays 0.
- DIVU issued, then MFLO in E at cycle 1 -> stall=1 cycles 1–10, stall_cnt=10; MFLO proceeds at cycle 11 with e_result=md_c (quotient 0x00000004 for 17/4).
- MTHI rs=0xDEADBEEF while IDLE -> md_we=1, md_sel=SEL_HI, cnt stays 0; following MFHI -> e_result=0xDEADBEEF, no stall.
- DIV with req=1 in the same cycle -> md_start=0, stall=0, state stays IDLE. MULT in RUN with req=1 -> stall=0 and cnt continues.
- Bench forces md_busy=0 at cycle 3 of a MULT -> proto_err=1 from the next edge, held until rst=0.
- rst asserted asynchronously mid-DIV (cnt=6) -> cnt=0, stall=0, stall_cnt=0 before the next clk edge.
